// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

   localparam int   DEPTH = 256;
   localparam int   AW    = 8;
   localparam logic P_CPU = 1'b0;
   localparam logic P_IO  = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      ACK     = 2'd3
   } state_t;

   function automatic logic in_range(input logic [31:0] addr, input int depth);
      return (addr < 32'(depth));
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-requester round-robin pick; prio only matters on a tie.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      grant = P_CPU;
      if (req == 2'b11) grant = prio;
      else if (req[1])  grant = P_IO;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and three-step access sequencer for the data memory.
//   state   | meaning
//   IDLE    | sample requests, latch the granted port's transaction
//   ACCESS  | address (and write strobe) presented to the memory
//   CAPTURE | memory read data valid, latched into the granted port's rdata
//   ACK     | one-cycle ack/err pulse to the granted port, prio flips
module dmem_arbiter #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [31:0]   addr0,
   input  logic [31:0]   addr1,
   input  logic [31:0]   wdata0,
   input  logic [31:0]   wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [31:0]   rdata0,
   output logic [31:0]   rdata1,
   output logic          err0,
   output logic          err1,
   output logic [AW-1:0] mem_adress,
   output logic [31:0]   mem_write_data,
   output logic          mem_write,
   input  logic [31:0]   mem_read_data
);
   import dmem_pkg::*;

   state_t      state;
   logic        prio;
   logic        g;
   logic        we_g;
   logic [31:0] addr_g;
   logic        gnt;
   logic        gnt_valid;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        ok_g;
   logic [31:0] rd_val;

   rr_arb2 u_arb (
      .req   ({req1, req0}),
      .prio  (prio),
      .grant (gnt),
      .valid (gnt_valid)
   );

   always_comb begin
      sel_we    = (gnt == P_IO) ? we1    : we0;
      sel_addr  = (gnt == P_IO) ? addr1  : addr0;
      sel_wdata = (gnt == P_IO) ? wdata1 : wdata0;
      ok_g      = in_range(addr_g, DEPTH);
      // Out-of-range reads return zero rather than aliasing into the array.
      rd_val    = ok_g ? mem_read_data : 32'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         prio           <= P_CPU;
         g              <= P_CPU;
         we_g           <= 1'b0;
         addr_g         <= '0;
         ack0           <= 1'b0;
         ack1           <= 1'b0;
         err0           <= 1'b0;
         err1           <= 1'b0;
         rdata0         <= '0;
         rdata1         <= '0;
         mem_adress     <= '0;
         mem_write_data <= '0;
         mem_write      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  state          <= ACCESS;
                  g              <= gnt;
                  we_g           <= sel_we;
                  addr_g         <= sel_addr;
                  mem_adress     <= sel_addr[AW-1:0];
                  mem_write_data <= sel_wdata;
                  mem_write      <= sel_we && in_range(sel_addr, DEPTH);
               end
            end
            ACCESS: begin
               state          <= CAPTURE;
               mem_write      <= 1'b0;
               mem_write_data <= '0;
            end
            CAPTURE: begin
               state      <= ACK;
               mem_adress <= '0;
               if (g == P_IO) begin
                  ack1 <= 1'b1;
                  err1 <= !ok_g;
                  if (!we_g) rdata1 <= rd_val;
               end else begin
                  ack0 <= 1'b1;
                  err0 <= !ok_g;
                  if (!we_g) rdata0 <= rd_val;
               end
            end
            ACK: begin
               state <= IDLE;
               ack0  <= 1'b0;
               ack1  <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               prio  <= ~g;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random single transactions.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic        ack0, ack1, err0, err1, mem_write;
   logic [31:0] rdata0, rdata1, mem_write_data;
   logic [7:0]  mem_adress;
   logic [31:0] mem_read_data = 0;

   logic [31:0] mem    [0:255];
   logic [31:0] refmem [0:255];
   int          mw_cnt = 0;
   int          vectors = 0;
   int          miscompares = 0;

   dmem_arbiter #(.DEPTH(256), .AW(8)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .mem_adress(mem_adress), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read_data(mem_read_data)
   );

   always #5 clock = ~clock;

   // Registered-read single-port memory.
   always @(posedge clock) begin
      if (mem_write) mem[mem_adress] <= mem_write_data;
      mem_read_data <= mem[mem_adress];
   end

   always @(negedge clock) if (mem_write) mw_cnt++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      req0 = 0; req1 = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Issues one transaction on port p and waits (bounded) for its ack.
   task automatic run_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int oth_ack, output int mw);
      int mw0;
      mw0 = mw_cnt; lat = 99; rd = 32'hx; er = 1'bx; oth_ack = 0;
      if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if ((p == 0) ? ack1 : ack0) oth_ack++;
         if ((p == 0) ? ack0 : ack1) begin
            lat = i;
            rd  = (p == 0) ? rdata0 : rdata1;
            er  = (p == 0) ? err0 : err1;
            break;
         end
      end
      req0 = 0; req1 = 0;
      @(negedge clock);
      mw = mw_cnt - mw0;
   endtask

   // Records the first n acks (port, cycle offset, rdata) while requests are held by the caller.
   task automatic collect_acks(input int n, output int port[4], output int t[4],
                               output logic [31:0] rd[4], output int dual);
      int k;
      k = 0; dual = 0;
      for (int j = 0; j < 4; j++) begin port[j] = -1; t[j] = -1; rd[j] = 32'hx; end
      for (int i = 1; i <= 30 && k < n; i++) begin
         @(negedge clock);
         if (ack0 && ack1) dual++;
         if (ack0) begin port[k] = 0; t[k] = i; rd[k] = rdata0; k++; end
         else if (ack1) begin port[k] = 1; t[k] = i; rd[k] = rdata1; k++; end
      end
   endtask

   task automatic test_reset();
      @(negedge clock); @(negedge clock); @(negedge clock);
      vectors++; if ({ack0, ack1, err0, err1} !== 4'b0) begin miscompares++;
         $display("FAIL reset_ack_err: got %b want 0000", {ack0, ack1, err0, err1}); end
      vectors++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin miscompares++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1); end
      vectors++; if ({mem_write, mem_adress, mem_write_data} !== 41'd0) begin miscompares++;
         $display("FAIL reset_mem: got we=%b a=%h d=%h want 0", mem_write, mem_adress, mem_write_data); end
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      int lat, oth, mw; logic [31:0] rd; logic er;
      mem[5] = 32'hDEADBEEF;
      run_txn(0, 1'b0, 32'd5, 32'd0, lat, rd, er, oth, mw);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL read_latency: got %0d want 3", lat); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_data: got %h want deadbeef", rd); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL read_err: got %b want 0", er); end
      vectors++; if (mw !== 0 || oth !== 0) begin miscompares++;
         $display("FAIL read_side: mem_write pulses %0d, other acks %0d, want 0/0", mw, oth); end
   endtask

   task automatic test_write_cross_read();
      int lat, oth, mw; logic [31:0] rd; logic er;
      run_txn(1, 1'b1, 32'd200, 32'h12345678, lat, rd, er, oth, mw);
      vectors++; if (lat !== 3 || mw !== 1) begin miscompares++;
         $display("FAIL write_io: latency %0d pulses %0d want 3/1", lat, mw); end
      vectors++; if (rd !== 32'd0 || er !== 1'b0) begin miscompares++;
         $display("FAIL write_io_hold: rdata1 %h err %b want 0/0", rd, er); end
      run_txn(0, 1'b0, 32'd200, 32'd0, lat, rd, er, oth, mw);
      vectors++; if (rd !== 32'h12345678 || mw !== 0) begin miscompares++;
         $display("FAIL cross_read: got %h pulses %0d want 12345678/0", rd, mw); end
   endtask

   task automatic test_contention();
      int port[4], t[4], dual; logic [31:0] rd[4];
      do_reset();
      mem[1] = 32'hA1A1A1A1; mem[2] = 32'hB2B2B2B2;
      req0 = 1; we0 = 0; addr0 = 32'd1;
      req1 = 1; we1 = 0; addr1 = 32'd2;
      collect_acks(4, port, t, rd, dual);
      req0 = 0; req1 = 0;
      @(negedge clock);
      vectors++; if (port[0] !== 0 || t[0] !== 3) begin miscompares++;
         $display("FAIL contend_first: port %0d at %0d want 0 at 3", port[0], t[0]); end
      vectors++; if (port[1] !== 1 || t[1] !== 7) begin miscompares++;
         $display("FAIL contend_second: port %0d at %0d want 1 at 7", port[1], t[1]); end
      vectors++; if (port[2] !== 0 || port[3] !== 1 || t[2] !== 11 || t[3] !== 15) begin miscompares++;
         $display("FAIL contend_alternate: %0d@%0d %0d@%0d want 0@11 1@15", port[2], t[2], port[3], t[3]); end
      vectors++; if (rd[0] !== 32'hA1A1A1A1 || rd[1] !== 32'hB2B2B2B2 || dual !== 0) begin miscompares++;
         $display("FAIL contend_data: got %h/%h dual %0d want a1a1a1a1/b2b2b2b2/0", rd[0], rd[1], dual); end
   endtask

   task automatic test_out_of_range();
      int lat, oth, mw; logic [31:0] rd; logic er;
      mem[0] = 32'h0BAD0BAD;
      run_txn(1, 1'b1, 32'd256, 32'hFFFFFFFF, lat, rd, er, oth, mw);
      vectors++; if (mw !== 0 || er !== 1'b1 || lat !== 3) begin miscompares++;
         $display("FAIL oor_write: pulses %0d err %b lat %0d want 0/1/3", mw, er, lat); end
      vectors++; if (rd !== 32'hB2B2B2B2) begin miscompares++;
         $display("FAIL oor_write_hold: rdata1 %h want b2b2b2b2", rd); end
      run_txn(1, 1'b0, 32'h0001_0000, 32'd0, lat, rd, er, oth, mw);
      vectors++; if (er !== 1'b1 || rd !== 32'd0 || mw !== 0) begin miscompares++;
         $display("FAIL oor_read: err %b rdata %h pulses %0d want 1/0/0", er, rd, mw); end
      vectors++; if (mem[0] !== 32'h0BAD0BAD) begin miscompares++;
         $display("FAIL oor_word0: got %h want 0bad0bad", mem[0]); end
   endtask

   task automatic test_reset_midop();
      int lat, oth, mw, stray, port[4], t[4], dual; logic [31:0] rd; logic er; logic [31:0] rds[4];
      // Serve port 0 so that prio points at port 1 before the abort.
      run_txn(0, 1'b0, 32'd3, 32'd0, lat, rd, er, oth, mw);
      req0 = 1; we0 = 1; addr0 = 32'd10; wdata0 = 32'hCAFEF00D;
      @(negedge clock);
      vectors++; if (mem_write !== 1'b1) begin miscompares++;
         $display("FAIL midop_access: mem_write %b want 1", mem_write); end
      reset = 1'b1; req0 = 0;
      @(negedge clock);
      vectors++; if (mem_write !== 1'b0 || ack0 !== 1'b0 || mem_adress !== 8'd0) begin miscompares++;
         $display("FAIL midop_abort: we %b ack0 %b addr %h want 0/0/0", mem_write, ack0, mem_adress); end
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clock); if (ack0 || ack1) stray++; end
      vectors++; if (stray !== 0) begin miscompares++; $display("FAIL midop_stray_ack: got %0d want 0", stray); end
      mem[11] = 32'h11111111; mem[12] = 32'h22222222;
      req0 = 1; we0 = 0; addr0 = 32'd11;
      req1 = 1; we1 = 0; addr1 = 32'd12;
      collect_acks(2, port, t, rds, dual);
      req0 = 0; req1 = 0;
      @(negedge clock);
      vectors++; if (port[0] !== 0 || t[0] !== 3) begin miscompares++;
         $display("FAIL midop_prio: first port %0d at %0d want 0 at 3", port[0], t[0]); end
      vectors++; if (port[1] !== 1 || t[1] !== 7 || rds[1] !== 32'h22222222) begin miscompares++;
         $display("FAIL midop_io: port %0d at %0d data %h want 1 at 7 22222222", port[1], t[1], rds[1]); end
   endtask

   task automatic test_random();
      int lat, oth, mw, p; logic [31:0] rd, a, d, exp; logic er, w, ok;
      logic [31:0] exp_rd[2]; logic known[2];
      known[0] = 0; known[1] = 0;
      for (int i = 0; i < 256; i++) refmem[i] = mem[i];
      for (int n = 0; n < 40; n++) begin
         p = int'($urandom_range(1, 0));
         w = 1'($urandom_range(1, 0));
         a = ($urandom_range(7, 0) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(255, 0));
         d = $urandom;
         ok = (a <= 32'd255);
         run_txn(p, w, a, d, lat, rd, er, oth, mw);
         vectors++; if (lat !== 3 || oth !== 0) begin miscompares++;
            $display("FAIL rnd_timing[%0d]: lat %0d other acks %0d want 3/0", n, lat, oth); end
         vectors++; if (er !== !ok) begin miscompares++;
            $display("FAIL rnd_err[%0d]: addr %h err %b want %b", n, a, er, !ok); end
         vectors++; if (mw !== ((w && ok) ? 1 : 0)) begin miscompares++;
            $display("FAIL rnd_write_pulses[%0d]: got %0d want %0d", n, mw, (w && ok) ? 1 : 0); end
         if (!w) begin
            exp = ok ? refmem[a[7:0]] : 32'd0;
            exp_rd[p] = exp; known[p] = 1;
            vectors++; if (rd !== exp) begin miscompares++;
               $display("FAIL rnd_read[%0d]: port %0d addr %h got %h want %h", n, p, a, rd, exp); end
         end else begin
            if (ok) refmem[a[7:0]] = d;
            if (known[p]) begin
               vectors++; if (rd !== exp_rd[p]) begin miscompares++;
                  $display("FAIL rnd_hold[%0d]: port %0d got %h want %h", n, p, rd, exp_rd[p]); end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
      test_reset();
      test_single_read();
      test_write_cross_read();
      test_contention();
      test_out_of_range();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
